uart_rx: RTL

Serial receiver for the UART link whose transmit side shifts out 1 start bit, 8 data bits LSB-first and 2 stop bits. It sits between the `rx` pad and the peripheral's register file. It samples the line at mid-bit using the shared baud divisor `brr` and presents each received byte through a one-entry valid/ready holding register. Framing and overrun errors are reported as sticky status bits.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 1 start / 8 data (LSB first) / 2 stop receiver, mid-bit sampling, one-entry holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits (adds err_parity).
module uart_rx #(
    parameter int BRR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BRR_W-1:0] brr,
    input  logic             rx,
    output logic [7:0]       data_in,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             err_frame,
    output logic             err_overrun,
`ifdef UART_RX_PARITY_EN
    output logic             err_parity,
`endif
    input  logic             err_clr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP1 = 3'd3;
    localparam logic [2:0] S_STOP2 = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd5;
`endif
    localparam logic [BRR_W-1:0] ONE     = BRR_W'(1);
    localparam logic [BRR_W-1:0] MIN_BRR = BRR_W'(4);

    logic [2:0]       state;
    logic             armed;
    logic             rx_m, rxs;
    logic [BRR_W-1:0] brr_eff, brr_l, cnt;
    logic [2:0]       bitcnt;
    logic [7:0]       shreg;
    logic             stop_bad;
`ifdef UART_RX_PARITY_EN
    logic             par_bad;
`endif
    logic             tick, done, load;

    assign brr_eff = (brr < MIN_BRR) ? MIN_BRR : brr;
    assign tick    = (cnt == '0);
    assign done    = (state == S_STOP2) && tick;
    // a consume in the completion cycle frees the slot for the new byte
    assign load    = done && (!valid || ready);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m        <= 1'b1;
            rxs         <= 1'b1;
            state       <= S_IDLE;
            armed       <= 1'b0;
            brr_l       <= '0;
            cnt         <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            stop_bad    <= 1'b0;
            data_in     <= '0;
            valid       <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            err_parity  <= 1'b0;
`endif
        end else begin
            rx_m <= rx;
            rxs  <= rx_m;
            if (!tick) cnt <= cnt - ONE;

            case (state)
                S_IDLE: begin
                    if (rxs) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state  <= S_START;
                        brr_l  <= brr_eff;
                        cnt    <= (brr_eff >> 1) - ONE;
                        bitcnt <= '0;
                    end
                end
                S_START: if (tick) begin
                    if (rxs) begin
                        state <= S_IDLE;
                        armed <= 1'b1;
                    end else begin
                        state <= S_DATA;
                        cnt   <= brr_l - ONE;
                    end
                end
                S_DATA: if (tick) begin
                    shreg  <= {rxs, shreg[7:1]};
                    bitcnt <= bitcnt + 3'd1;
                    cnt    <= brr_l - ONE;
                    if (bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state <= S_PAR;
`else
                        state <= S_STOP1;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PAR: if (tick) begin
                    par_bad <= ^{rxs, shreg};
                    state   <= S_STOP1;
                    cnt     <= brr_l - ONE;
                end
`endif
                S_STOP1: if (tick) begin
                    stop_bad <= !rxs;
                    state    <= S_STOP2;
                    cnt      <= brr_l - ONE;
                end
                S_STOP2: if (tick) begin
                    // line must return high before another start is accepted
                    state <= S_IDLE;
                    armed <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            if (load) begin
                data_in <= shreg;
                valid   <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            // set events take priority over err_clr
            if (done && (stop_bad || !rxs)) err_frame <= 1'b1;
            else if (err_clr)               err_frame <= 1'b0;

            if (done && !load) err_overrun <= 1'b1;
            else if (err_clr)  err_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (done && par_bad) err_parity <= 1'b1;
            else if (err_clr)    err_parity <= 1'b0;
`endif
        end
    end

endmodule
